// File: rtl/fpu_drv_pkg.sv
// Shared types and constants for the FPU operand driver: FSM states,
// one-hot FPU status codes and the packed operand-pair layout.
package fpu_drv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      OUTPUT = 2'd2
   } drv_state_t;

   // FPU status_out is one-hot; the driver forwards it untouched.
   localparam logic [3:0] ST_EXACT   = 4'b0001;
   localparam logic [3:0] ST_OVF     = 4'b0010;
   localparam logic [3:0] ST_UNF     = 4'b0100;
   localparam logic [3:0] ST_INEXACT = 4'b1000;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } operand_pair_t;

   localparam int PAIR_W = $bits(operand_pair_t);

endpackage

// File: rtl/fpu_drv_fifo.sv
// Synchronous FIFO with a combinational head read, so the consumer can pop
// and use the head on the same edge. Storage is not reset; only state is.
module fpu_drv_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fpu_operand_driver.sv
// Feeds buffered operand pairs to a strobe-less FPU, holds them for a fixed
// settle window, then captures and offers {result, status} to the host.
module fpu_operand_driver
   import fpu_drv_pkg::*;
#(
   parameter int HOLD_CYCLES = 5,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clock_100Khz,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] op_a_out,
   output logic [31:0] op_b_out,
   input  logic [31:0] fpu_data_in,
   input  logic [3:0]  fpu_status_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [3:0]  res_status,
   output logic        busy
);

   localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   drv_state_t    state_reg;
   logic [7:0]    hold_cnt_reg;
   operand_pair_t head_pair;
   operand_pair_t push_pair;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   assign push_pair = '{a: in_a, b: in_b};
   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && !fifo_full;
   assign busy      = (state_reg != IDLE) || (fifo_count != '0);

   // A pop is always paired with an operand load; it happens from IDLE, or
   // from OUTPUT on the result handshake edge when another pair is waiting.
   assign fifo_pop  = !fifo_empty &&
                      ((state_reg == IDLE) || ((state_reg == OUTPUT) && res_ready));

   fpu_drv_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAIR_W)
   ) u_fifo (
      .clk   (clock_100Khz),
      .rst_n (reset),
      .push  (fifo_push),
      .wdata (push_pair),
      .pop   (fifo_pop),
      .rdata (head_pair),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         hold_cnt_reg <= '0;
         op_a_out     <= '0;
         op_b_out     <= '0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_status   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (fifo_pop) begin
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               hold_cnt_reg <= hold_cnt_reg + 1'b1;
               if (hold_cnt_reg == HOLD_LAST) begin
                  res_data   <= fpu_data_in;
                  res_status <= fpu_status_in;
                  res_valid  <= 1'b1;
                  state_reg  <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state_reg <= fifo_pop ? HOLD : IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase

         // Operands only move on a load, so the FPU inputs stay quiet otherwise.
         if (fifo_pop) begin
            op_a_out     <= head_pair.a;
            op_b_out     <= head_pair.b;
            hold_cnt_reg <= '0;
         end
      end
   end

endmodule

// File: doc/fpu_operand_driver.md
# fpu_operand_driver

Drives operand pairs into the FPU and collects its results. A host pushes {A, B} operand pairs through a valid/ready port into a small FIFO. The block presents each pair on the FPU's Op_A_in/Op_B_in and holds it stable for a fixed settle window, because the FPU has no start or done strobe. It then samples data_out/status_out and returns {result, status} on a valid/ready result port. It sits between the host or sequencer logic and the FPU, and it is the initiator side of the FPU operand/result interface.

## Interface
- HOLD_CYCLES, 5: clock edges operands are held before the FPU result is sampled; legal range 2..255.
- FIFO_DEPTH, 4: operand-pair FIFO entries; must be a power of two, at least 2.
- clock_100Khz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; one clock domain only.
- in_valid  in  1  host offers an operand pair.
- in_ready  out  1  FIFO not full.
- in_a  in  32  IEEE-754 single operand A.
- in_b  in  32  IEEE-754 single operand B.
- op_a_out  out  32  to FPU Op_A_in.
- op_b_out  out  32  to FPU Op_B_in.
- fpu_data_in  in  32  from FPU data_out.
- fpu_status_in  in  4  from FPU status_out; one-hot encoding:
  - EXACT = 0001
  - OVERFLOW = 0010
  - UNDERFLOW = 0100
  - INEXACT = 1000
- res_valid  out  1  result held for the host.
- res_ready  in  1  host accepts the result.
- res_data  out  32  captured FPU result.
- res_status  out  4  captured FPU status.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- Reset (reset=0) clears the following, asynchronously:
  - FIFO pointers and count.
  - FSM to IDLE; hold counter to 0.
  - op_a_out, op_b_out, res_data and res_status to 0.
  - res_valid to 0.
  - After reset, in_ready=1 and busy=0.
- Push: an operand pair is written on an edge where in_valid && in_ready. in_ready is the registered-state decode !full. There is no bypass around the FIFO.
- FSM states: IDLE, HOLD, OUTPUT.
  - IDLE: if the FIFO is not empty, pop the head, load op_a_out/op_b_out, clear the counter, go to HOLD.
  - HOLD: increment the counter each edge. On the edge where counter == HOLD_CYCLES-1, register fpu_data_in and fpu_status_in into res_data/res_status, set res_valid=1, go to OUTPUT.
  - OUTPUT: hold res_* stable while res_valid && !res_ready. On the handshake edge:
    - if the FIFO is not empty, pop the next pair, load the operands, clear the counter, go to HOLD (back-to-back);
    - otherwise go to IDLE.
    - In both cases res_valid drops on that edge.
- op_a_out and op_b_out keep the last-loaded pair in IDLE and OUTPUT, so FPU inputs change only on a load.
- Simultaneous push and pop on the same edge: both happen and the count is unchanged.
- Full FIFO: in_ready=0. A pop on edge k makes in_ready=1 after edge k; a full FIFO never accepts in the pop cycle.
- Result status is passed through unmodified. No arithmetic is done on the data.
- Reset mid-operation: the in-flight pair, buffered pairs and any unaccepted result are discarded. No partial result appears after reset releases.

## Timing
- Push on edge k, empty FIFO, FSM IDLE:
  - pop and operand load at edge k+1;
  - capture at edge k+1+HOLD_CYCLES;
  - res_valid is first high in the cycle after that edge, i.e. HOLD_CYCLES+1 edges after the push.
- Back-to-back: when res_ready is held high, one result is produced every HOLD_CYCLES+1 edges.
- Operands are stable for exactly HOLD_CYCLES edges before sampling. The FPU's worst-case settle time must be below HOLD_CYCLES-1 cycles.
- res_valid, once high, stays high until the handshake edge (no retraction).

## Structure
- Package fpu_drv_pkg holds:
  - the state enum (IDLE, HOLD, OUTPUT);
  - the status one-hot localparams (ST_EXACT, ST_OVF, ST_UNF, ST_INEXACT);
  - a typedef for the 64-bit operand-pair struct {a, b}.
- Sub-module fpu_drv_fifo: synchronous FIFO, parameterised on depth and width, with full/empty/count and async active-low reset. The top level holds the FSM, counter and output registers.

## Test plan
The bench uses an FPU stub that computes A+B with 3-cycle latency and reports status EXACT=0001.
- Reset, then push A=0x3FC00000 and B=0x40100000 (1.5+2.25), res_ready=1 -> res_data=0x40700000 (3.75) and res_status=0001, with res_valid rising exactly 6 edges after the push.
- Push 0x41000000 and 0xC1000000 (8.0 + -8.0) -> res_data=0x00000000.
- Push 5 pairs with res_ready=0 -> in_ready drops after the 4th push is buffered behind the in-flight pair. res_data stays stable while res_valid is high. Releasing res_ready drains all pairs in order.
- Check back-to-back spacing with res_ready=1 and 3 queued pairs -> res_valid pulses every 6 edges, and op_a_out changes only on load edges.
- Assert reset during HOLD with 2 pairs queued -> all outputs 0 and busy=0 immediately. No res_valid after release.
- Simultaneous push and result handshake with FIFO count=2 -> count stays 2 and ordering is preserved.
